game_renderer: RTL and testbench
================================

GAME_RENDERER -- requirements
Module: game_renderer

Interface
REQ-001 Parameter FLASH_FRAMES, default 30, sets the number of frames the ship blinks after a collision.
REQ-002 Parameter SHIP_SIZE, default 16, is the ship square edge in pixels.
REQ-003 Parameter METEOR_SIZE, default 12, is the meteor square edge in pixels.
REQ-004 clk  in  1: the single clock.
REQ-005 reset  in  1: synchronous, active-high reset.
REQ-006 pixel_x  in  10, pixel_y  in  9: current scan pixel.
REQ-007 pixel_valid  in  1: pixel_x/pixel_y are in the visible area this cycle.
REQ-008 frame_start  in  1: one-cycle pulse at vblank start.
REQ-009 ship_x  in  10, ship_y  in  9: ship top-left from game_controller.
REQ-010 meteor_x  in  10 x6, meteor_y  in  9 x6, meteor_active  in  6: meteor state.
REQ-011 lives  in  3, game_over  in  1, collision  in  1: game status.
REQ-012 rgb  out  24: pixel colour {R,G,B}.
REQ-013 rgb_valid  out  1: rgb corresponds to the pixel presented 2 cycles earlier.

Function
REQ-014 Snapshot: all game inputs except collision are latched only on frame_start; drawing uses the snapshot, so there is no mid-frame tearing.
REQ-015 Latency: the pipeline is fixed at 2 cycles; rgb_valid is pixel_valid delayed 2 cycles; rgb is 0 when rgb_valid=0.
REQ-016 Hit test: a pixel hits a box when px>=x and px<x+SIZE and py>=y and py<y+SIZE, computed 1 bit wider than the operands; a box near the edge clips and never wraps.
REQ-017 Priority: game_over border (pixels within 8 of any screen edge, 640x480) > ship > any active meteor > lives HUD > background.
REQ-018 Colours: border FF0000; ship 00FFFF; meteor FF8000; lives 00FF00; background 000000.
REQ-019 Lives HUD: icon i (0..lives-1) is an 8x8 square at x=4+12*i, y=4; lives values above 6 are clamped to 6.
REQ-020 Collision edge: a rising edge is detected on collision at every clock, independent of the snapshot.
REQ-021 Flash counter: a collision edge loads FLASH_FRAMES; each frame_start decrements it while it is nonzero.
REQ-022 If a collision edge and frame_start coincide, the load wins.
REQ-023 The ship is drawn when flash==0 or flash[1]==1, using the flash value sampled at frame_start.
REQ-024 Inactive meteors never draw, regardless of their position.

Reset
REQ-025 Reset clears rgb and rgb_valid, the pipeline registers, the flash counter, the scroll counter and the collision-edge history.
REQ-026 Reset clears the snapshot: ship at (0,0), meteor_active=0, lives=0, game_over=0.
REQ-027 Reset mid-frame forces rgb_valid=0 from the next cycle; output resumes 2 cycles after reset deasserts with pixel_valid=1.

Configuration
REQ-028 With RENDER_STARFIELD_EN defined, background pixels where (pixel_x[7:0] ^ (pixel_y[7:0]+scroll)) == 8'h5A draw 808080.
REQ-029 With RENDER_STARFIELD_EN defined, an 8-bit scroll counter increments on each frame_start.
REQ-030 Without RENDER_STARFIELD_EN, the background is solid 000000 and no scroll register exists.

Structure
REQ-031 The shared package game_pkg holds NUM_METEORS=6, SCREEN_W=640, SCREEN_H=480, the rgb_t typedef and all colour constants.
REQ-032 The combinational box compare is the sub-module sprite_hit (parameter SIZE), instantiated 7 times: 1 ship and 6 meteors.

Verification
REQ-033 The bench shall cover these scenarios:
- Ship at (100,50) snapshotted; pixel (100,50) -> 00FFFF 2 cycles later; (116,50) and (99,50) -> background.
- Meteor 2 active at (100,50) and overlapping the ship; pixel (105,55) -> 00FFFF; same pixel with ship moved away -> FF8000; meteor_active[2]=0 -> background.
- Ship_x changes mid-frame -> output unchanged until the next frame_start.
- Collision pulse -> ship hidden on frames where flash[1]=0 for 30 frames, then steadily visible; collision edge on the same cycle as frame_start reloads 30.
- lives=2 -> pixels (4,4) and (16,4) green, (28,4) background.
- game_over=1 -> pixel (3,200) FF0000 even with the ship there.
- Ship at x=630 -> pixels 630..639 drawn and pixel (0,y) not drawn.
- Reset asserted mid-line -> rgb_valid=0 the next cycle and the snapshot cleared.

Source files
------------

// File: rtl/game_pkg.sv
`default_nettype none
// game_pkg: shared screen geometry, colours, snapshot record and lives-HUD helper.
// Revision: 1.0
package game_pkg;

  localparam int NUM_METEORS = 6;
  localparam int SCREEN_W    = 640;
  localparam int SCREEN_H    = 480;
  localparam int BORDER_W    = 8;

  localparam int HUD_MAX   = 6;
  localparam int HUD_X0    = 4;
  localparam int HUD_Y0    = 4;
  localparam int HUD_PITCH = 12;
  localparam int HUD_ICON  = 8;

  typedef logic [23:0] rgb_t;

  localparam rgb_t c_RGB_BORDER = 24'hFF0000;
  localparam rgb_t c_RGB_SHIP   = 24'h00FFFF;
  localparam rgb_t c_RGB_METEOR = 24'hFF8000;
  localparam rgb_t c_RGB_LIVES  = 24'h00FF00;
  localparam rgb_t c_RGB_BG     = 24'h000000;
  localparam rgb_t c_RGB_STAR   = 24'h808080;

  typedef struct packed {
    logic [9:0]                  ship_x;
    logic [8:0]                  ship_y;
    logic [NUM_METEORS-1:0][9:0] meteor_x;
    logic [NUM_METEORS-1:0][8:0] meteor_y;
    logic [NUM_METEORS-1:0]      meteor_active;
    logic [2:0]                  lives;
    logic                        game_over;
  } snap_t;

  // One icon per remaining life; counts above HUD_MAX show as HUD_MAX icons.
  function automatic logic hud_hit(input logic [9:0] px, input logic [8:0] py,
                                   input logic [2:0] lives);
    logic [2:0] n;
    logic [9:0] x0;
    logic       hit;
    n   = (lives > 3'(HUD_MAX)) ? 3'(HUD_MAX) : lives;
    hit = 1'b0;
    for (int i = 0; i < HUD_MAX; i++) begin
      x0 = 10'(HUD_X0 + HUD_PITCH * i);
      if ((3'(i) < n) && (px >= x0) && (px < x0 + 10'(HUD_ICON)) &&
          (py >= 9'(HUD_Y0)) && (py < 9'(HUD_Y0 + HUD_ICON)))
        hit = 1'b1;
    end
    return hit;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sprite_hit.sv
`default_nettype none
// sprite_hit: combinational point-in-square test; the far edge is computed one bit wider so boxes clip at the screen edge.
// Revision: 1.0
module sprite_hit #(
  parameter int SIZE = 16
) (
  input  logic [9:0] i_px,
  input  logic [8:0] i_py,
  input  logic [9:0] i_x,
  input  logic [8:0] i_y,
  output logic       o_hit
);

  localparam logic [10:0] c_SIZE_X = 11'(SIZE);
  localparam logic [9:0]  c_SIZE_Y = 10'(SIZE);

  logic [10:0] w_x_end;
  logic [9:0]  w_y_end;

  assign w_x_end = {1'b0, i_x} + c_SIZE_X;
  assign w_y_end = {1'b0, i_y} + c_SIZE_Y;

  assign o_hit = (i_px >= i_x) && ({1'b0, i_px} < w_x_end) &&
                 (i_py >= i_y) && ({1'b0, i_py} < w_y_end);

endmodule
`default_nettype wire

// File: rtl/game_renderer.sv
`default_nettype none
// game_renderer: 2-cycle pixel colour pipeline drawing border, ship, meteors and lives HUD from a per-frame snapshot.
// Optional feature macro RENDER_STARFIELD_EN adds a scrolling starfield background. Revision: 1.0
module game_renderer
  import game_pkg::*;
#(
  parameter int FLASH_FRAMES = 30,
  parameter int SHIP_SIZE    = 16,
  parameter int METEOR_SIZE  = 12
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [9:0]                  pixel_x,
  input  logic [8:0]                  pixel_y,
  input  logic                        pixel_valid,
  input  logic                        frame_start,
  input  logic [9:0]                  ship_x,
  input  logic [8:0]                  ship_y,
  input  logic [NUM_METEORS-1:0][9:0] meteor_x,
  input  logic [NUM_METEORS-1:0][8:0] meteor_y,
  input  logic [NUM_METEORS-1:0]      meteor_active,
  input  logic [2:0]                  lives,
  input  logic                        game_over,
  input  logic                        collision,
  output rgb_t                        rgb,
  output logic                        rgb_valid
);

  localparam int c_FLASH_W = ($clog2(FLASH_FRAMES + 1) < 2) ? 2 : $clog2(FLASH_FRAMES + 1);
  localparam logic [c_FLASH_W-1:0] c_FLASH_LOAD = c_FLASH_W'(FLASH_FRAMES);
  localparam logic [c_FLASH_W-1:0] c_FLASH_ONE  = c_FLASH_W'(1);

  localparam logic [9:0] c_BX_LO = 10'(BORDER_W);
  localparam logic [9:0] c_BX_HI = 10'(SCREEN_W - BORDER_W);
  localparam logic [8:0] c_BY_LO = 9'(BORDER_W);
  localparam logic [8:0] c_BY_HI = 9'(SCREEN_H - BORDER_W);

  snap_t                r_snap;
  logic                 r_ship_vis;
  logic [c_FLASH_W-1:0] r_flash;
  logic                 r_coll_d;
  logic                 w_coll_edge;

  assign w_coll_edge = collision & ~r_coll_d;

  // Collision edges are seen every clock; a load beats a coincident frame decrement.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_coll_d <= 1'b0;
      r_flash  <= '0;
    end else begin
      r_coll_d <= collision;
      if (w_coll_edge)
        r_flash <= c_FLASH_LOAD;
      else if (frame_start && (r_flash != '0))
        r_flash <= r_flash - c_FLASH_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_snap     <= '0;
      r_ship_vis <= 1'b1;
    end else if (frame_start) begin
      r_snap.ship_x        <= ship_x;
      r_snap.ship_y        <= ship_y;
      r_snap.meteor_x      <= meteor_x;
      r_snap.meteor_y      <= meteor_y;
      r_snap.meteor_active <= meteor_active;
      r_snap.lives         <= lives;
      r_snap.game_over     <= game_over;
      r_ship_vis           <= (r_flash == '0) || r_flash[1];
    end
  end

  logic w_star;
`ifdef RENDER_STARFIELD_EN
  logic [7:0] r_scroll;

  always_ff @(posedge clk) begin
    if (reset)
      r_scroll <= 8'd0;
    else if (frame_start)
      r_scroll <= r_scroll + 8'd1;
  end

  assign w_star = ((pixel_x[7:0] ^ (pixel_y[7:0] + r_scroll)) == 8'h5A);
`else
  assign w_star = 1'b0;
`endif

  logic                   w_ship_hit;
  logic [NUM_METEORS-1:0] w_met_hit;
  logic                   w_border;
  logic                   w_hud;

  sprite_hit #(.SIZE(SHIP_SIZE)) u_ship_hit (
    .i_px  (pixel_x),
    .i_py  (pixel_y),
    .i_x   (r_snap.ship_x),
    .i_y   (r_snap.ship_y),
    .o_hit (w_ship_hit)
  );

  for (genvar g = 0; g < NUM_METEORS; g++) begin : g_meteor
    sprite_hit #(.SIZE(METEOR_SIZE)) u_meteor_hit (
      .i_px  (pixel_x),
      .i_py  (pixel_y),
      .i_x   (r_snap.meteor_x[g]),
      .i_y   (r_snap.meteor_y[g]),
      .o_hit (w_met_hit[g])
    );
  end

  assign w_border = r_snap.game_over &&
                    ((pixel_x < c_BX_LO) || (pixel_x >= c_BX_HI) ||
                     (pixel_y < c_BY_LO) || (pixel_y >= c_BY_HI));
  assign w_hud    = hud_hit(pixel_x, pixel_y, r_snap.lives);

  logic r_s1_valid;
  logic r_s1_border;
  logic r_s1_ship;
  logic r_s1_meteor;
  logic r_s1_hud;
  logic r_s1_star;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_s1_valid  <= 1'b0;
      r_s1_border <= 1'b0;
      r_s1_ship   <= 1'b0;
      r_s1_meteor <= 1'b0;
      r_s1_hud    <= 1'b0;
      r_s1_star   <= 1'b0;
    end else begin
      r_s1_valid  <= pixel_valid;
      r_s1_border <= w_border;
      r_s1_ship   <= w_ship_hit && r_ship_vis;
      r_s1_meteor <= |(w_met_hit & r_snap.meteor_active);
      r_s1_hud    <= w_hud;
      r_s1_star   <= w_star;
    end
  end

  rgb_t w_rgb;

  always_comb begin
    w_rgb = c_RGB_BG;
    if (r_s1_border)
      w_rgb = c_RGB_BORDER;
    else if (r_s1_ship)
      w_rgb = c_RGB_SHIP;
    else if (r_s1_meteor)
      w_rgb = c_RGB_METEOR;
    else if (r_s1_hud)
      w_rgb = c_RGB_LIVES;
    else if (r_s1_star)
      w_rgb = c_RGB_STAR;
  end

  rgb_t r_rgb;
  logic r_rgb_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rgb       <= c_RGB_BG;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= r_s1_valid;
      r_rgb       <= r_s1_valid ? w_rgb : c_RGB_BG;
    end
  end

  assign rgb       = r_rgb;
  assign rgb_valid = r_rgb_valid;

endmodule
`default_nettype wire

// File: tb/tb_game_renderer.sv
`default_nettype none
// tb_game_renderer: table vectors, directed corner sequences and randomized frames checked against a behavioural model.
// Revision: 1.0
module tb_game_renderer;

  logic            clk = 1'b0;
  logic            reset;
  logic [9:0]      pixel_x;
  logic [8:0]      pixel_y;
  logic            pixel_valid;
  logic            frame_start;
  logic [9:0]      ship_x;
  logic [8:0]      ship_y;
  logic [5:0][9:0] meteor_x;
  logic [5:0][8:0] meteor_y;
  logic [5:0]      meteor_active;
  logic [2:0]      lives;
  logic            game_over;
  logic            collision;
  logic [23:0]     rgb;
  logic            rgb_valid;

  always #5 clk = ~clk;

  game_renderer dut (
    .clk           (clk),
    .reset         (reset),
    .pixel_x       (pixel_x),
    .pixel_y       (pixel_y),
    .pixel_valid   (pixel_valid),
    .frame_start   (frame_start),
    .ship_x        (ship_x),
    .ship_y        (ship_y),
    .meteor_x      (meteor_x),
    .meteor_y      (meteor_y),
    .meteor_active (meteor_active),
    .lives         (lives),
    .game_over     (game_over),
    .collision     (collision),
    .rgb           (rgb),
    .rgb_valid     (rgb_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state: what the screen should show this frame.
  int         m_sx, m_sy, m_lives, m_flash;
  int         m_mx[6];
  int         m_my[6];
  logic [5:0] m_act;
  bit         m_go, m_vis;

  typedef struct packed {
    logic [9:0]  x;
    logic [8:0]  y;
    logic [23:0] exp;
  } vec_t;

  vec_t tbl[12];

  function automatic logic [23:0] ref_rgb(input int x, input int y);
    int n;
    if (m_go && (x < 8 || x > 631 || y < 8 || y > 471)) return 24'hFF0000;
    if (m_vis && x >= m_sx && x < m_sx + 16 && y >= m_sy && y < m_sy + 16) return 24'h00FFFF;
    for (int i = 0; i < 6; i++)
      if (m_act[i] && x >= m_mx[i] && x < m_mx[i] + 12 && y >= m_my[i] && y < m_my[i] + 12)
        return 24'hFF8000;
    n = (m_lives > 6) ? 6 : m_lives;
    if (y >= 4 && y < 12 && x >= 4 && (x - 4) / 12 < n && (x - 4) % 12 < 8) return 24'h00FF00;
    return 24'h000000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    m_sx = 0; m_sy = 0; m_lives = 0; m_flash = 0;
    m_act = '0; m_go = 0; m_vis = 1;
    for (int i = 0; i < 6; i++) begin
      m_mx[i] = 0;
      m_my[i] = 0;
    end
  endtask

  task automatic frame(input bit coll = 1'b0);
    frame_start = 1'b1;
    if (coll) collision = 1'b1;
    m_sx = int'(ship_x); m_sy = int'(ship_y);
    for (int i = 0; i < 6; i++) begin
      m_mx[i] = int'(meteor_x[i]);
      m_my[i] = int'(meteor_y[i]);
    end
    m_act = meteor_active; m_lives = int'(lives); m_go = game_over;
    m_vis = (m_flash == 0) || ((m_flash / 2) % 2 == 1);
    if (coll) m_flash = 30;
    else if (m_flash > 0) m_flash = m_flash - 1;
    step();
    frame_start = 1'b0;
    collision   = 1'b0;
  endtask

  task automatic pulse_coll();
    collision = 1'b1;
    m_flash   = 30;
    step();
    collision = 1'b0;
  endtask

  task automatic check_pixel(input string name, input int x, input int y, input logic [23:0] exp);
    pixel_x = 10'(x);
    pixel_y = 9'(y);
    pixel_valid = 1'b1;
    step();
    pixel_valid = 1'b0;
    step();
    chk({name, " valid"}, 32'(rgb_valid), 32'd1);
    chk(name, 32'(rgb), 32'(exp));
  endtask

  task automatic check_model(input string name, input int x, input int y);
    check_pixel(name, x, y, ref_rgb(x, y));
  endtask

  function automatic int clampx(input int v);
    return (v < 0) ? 0 : (v > 639) ? 639 : v;
  endfunction

  function automatic int clampy(input int v);
    return (v < 0) ? 0 : (v > 479) ? 479 : v;
  endfunction

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int hidden;
    int px, py, k;
    reset = 1'b1; pixel_x = '0; pixel_y = '0; pixel_valid = 1'b0; frame_start = 1'b0;
    ship_x = '0; ship_y = '0; meteor_x = '0; meteor_y = '0; meteor_active = '0;
    lives = '0; game_over = 1'b0; collision = 1'b0;
    model_reset();
    repeat (3) step();
    chk("reset rgb_valid", 32'(rgb_valid), 32'd0);
    chk("reset rgb", 32'(rgb), 32'd0);
    reset = 1'b0;

    // Cleared snapshot: ship at origin, nothing else.
    check_pixel("post-reset bg", 20, 20, 24'h000000);
    check_pixel("post-reset ship origin", 0, 0, 24'h00FFFF);
    step();
    chk("idle rgb_valid", 32'(rgb_valid), 32'd0);
    chk("idle rgb", 32'(rgb), 32'd0);

    // Table vectors: ship at (100,50), two lives.
    ship_x = 10'd100; ship_y = 9'd50; lives = 3'd2;
    frame();
    tbl[0]  = '{10'd100, 9'd50, 24'h00FFFF};
    tbl[1]  = '{10'd115, 9'd65, 24'h00FFFF};
    tbl[2]  = '{10'd116, 9'd50, 24'h000000};
    tbl[3]  = '{10'd99,  9'd50, 24'h000000};
    tbl[4]  = '{10'd100, 9'd66, 24'h000000};
    tbl[5]  = '{10'd4,   9'd4,  24'h00FF00};
    tbl[6]  = '{10'd11,  9'd11, 24'h00FF00};
    tbl[7]  = '{10'd16,  9'd4,  24'h00FF00};
    tbl[8]  = '{10'd23,  9'd4,  24'h00FF00};
    tbl[9]  = '{10'd28,  9'd4,  24'h000000};
    tbl[10] = '{10'd12,  9'd4,  24'h000000};
    tbl[11] = '{10'd4,   9'd12, 24'h000000};
    for (int i = 0; i < 12; i++)
      check_pixel($sformatf("vec%0d (%0d,%0d)", i, tbl[i].x, tbl[i].y),
                  int'(tbl[i].x), int'(tbl[i].y), tbl[i].exp);

    // Lives clamp: 7 shows six icons.
    lives = 3'd7;
    frame();
    check_pixel("lives7 icon5", 64, 4, 24'h00FF00);
    check_pixel("lives7 no icon6", 76, 4, 24'h000000);
    lives = 3'd2;

    // Mid-frame ship move is invisible until the next frame_start.
    ship_x = 10'd300;
    check_pixel("midframe old pos", 100, 50, 24'h00FFFF);
    check_pixel("midframe new pos", 300, 50, 24'h000000);
    frame();
    check_pixel("nextframe new pos", 300, 50, 24'h00FFFF);
    check_pixel("nextframe old pos", 100, 50, 24'h000000);

    // Meteor 2 under the ship, then alone, then inactive.
    ship_x = 10'd100; ship_y = 9'd50;
    meteor_x[2] = 10'd100; meteor_y[2] = 9'd50; meteor_active = 6'b000100;
    frame();
    check_pixel("ship over meteor", 105, 55, 24'h00FFFF);
    ship_x = 10'd300; ship_y = 9'd300;
    frame();
    check_pixel("meteor alone", 105, 55, 24'hFF8000);
    check_pixel("meteor far corner", 111, 61, 24'hFF8000);
    check_pixel("meteor right edge", 112, 55, 24'h000000);
    meteor_active = 6'b000000;
    frame();
    check_pixel("meteor inactive", 105, 55, 24'h000000);

    // Game-over border beats the ship.
    game_over = 1'b1; ship_x = 10'd0; ship_y = 9'd195;
    frame();
    check_pixel("border over ship", 3, 200, 24'hFF0000);
    check_pixel("ship inside border", 10, 200, 24'h00FFFF);
    check_pixel("border bottom-right", 639, 479, 24'hFF0000);
    check_pixel("border right", 632, 100, 24'hFF0000);
    check_pixel("inside right", 631, 100, 24'h000000);
    check_pixel("centre", 320, 240, 24'h000000);
    game_over = 1'b0;

    // Ship clipped at the right and bottom edges, no wrap.
    ship_x = 10'd630; ship_y = 9'd100;
    frame();
    check_pixel("clip x630", 630, 100, 24'h00FFFF);
    check_pixel("clip x639", 639, 100, 24'h00FFFF);
    check_pixel("clip x629", 629, 100, 24'h000000);
    check_pixel("no wrap x0", 0, 100, 24'h000000);
    ship_y = 9'd470;
    frame();
    check_pixel("clip y479", 635, 479, 24'h00FFFF);
    check_pixel("no wrap y0", 635, 0, 24'h000000);

    // Collision flash: 15 hidden frames over 30, then steadily visible.
    ship_x = 10'd200; ship_y = 9'd200;
    frame();
    pulse_coll();
    hidden = 0;
    for (int f = 0; f < 34; f++) begin
      frame();
      check_model($sformatf("flash frame %0d", f), 205, 205);
      if (rgb == 24'h000000) hidden++;
    end
    chk("flash hidden count", 32'(hidden), 32'd15);

    // Collision edge coincident with frame_start reloads the counter.
    frame(1'b1);
    check_pixel("coincide sample0", 205, 205, 24'h00FFFF);
    frame();
    check_pixel("reload sample30", 205, 205, 24'h00FFFF);
    frame();
    check_pixel("reload sample29", 205, 205, 24'h000000);
    frame();
    check_pixel("reload sample28", 205, 205, 24'h000000);
    frame();
    check_pixel("reload sample27", 205, 205, 24'h00FFFF);
    repeat (30) frame();

    // Randomized frames against the model.
    for (int r = 0; r < 24; r++) begin
      ship_x = 10'($urandom_range(0, 639));
      ship_y = 9'($urandom_range(0, 479));
      for (int i = 0; i < 6; i++) begin
        if ($urandom_range(0, 2) == 0) begin
          meteor_x[i] = 10'(clampx(int'(ship_x) - 8 + int'($urandom_range(0, 20))));
          meteor_y[i] = 9'(clampy(int'(ship_y) - 8 + int'($urandom_range(0, 20))));
        end else begin
          meteor_x[i] = 10'($urandom_range(0, 639));
          meteor_y[i] = 9'($urandom_range(0, 479));
        end
      end
      meteor_active = 6'($urandom);
      lives = 3'($urandom_range(0, 7));
      game_over = ($urandom_range(0, 3) == 0);
      if ($urandom_range(0, 3) == 0) pulse_coll();
      frame();
      for (int p = 0; p < 10; p++) begin
        k = int'($urandom_range(0, 3));
        if (k == 0) begin
          px = int'($urandom_range(0, 639)); py = int'($urandom_range(0, 479));
        end else if (k == 1) begin
          px = clampx(m_sx - 4 + int'($urandom_range(0, 24)));
          py = clampy(m_sy - 4 + int'($urandom_range(0, 24)));
        end else if (k == 2) begin
          px = clampx(m_mx[p % 6] - 3 + int'($urandom_range(0, 18)));
          py = clampy(m_my[p % 6] - 3 + int'($urandom_range(0, 18)));
        end else begin
          px = int'($urandom_range(0, 80)); py = int'($urandom_range(0, 15));
        end
        check_model($sformatf("rand f%0d p%0d (%0d,%0d)", r, p, px, py), px, py);
      end
    end

    // Reset asserted mid-line clears output and snapshot.
    game_over = 1'b1; lives = 3'd3; ship_x = 10'd100; ship_y = 9'd50; meteor_active = '0;
    frame();
    pixel_x = 10'd3; pixel_y = 9'd200; pixel_valid = 1'b1;
    step();
    step();
    chk("pre-reset stream valid", 32'(rgb_valid), 32'd1);
    chk("pre-reset stream rgb", 32'(rgb), 32'hFF0000);
    reset = 1'b1;
    step();
    chk("midline reset rgb_valid", 32'(rgb_valid), 32'd0);
    chk("midline reset rgb", 32'(rgb), 32'd0);
    reset = 1'b0;
    pixel_valid = 1'b0;
    model_reset();
    check_pixel("after reset border gone", 3, 200, 24'h000000);
    check_pixel("after reset ship moved", 100, 50, 24'h000000);
    check_pixel("after reset ship origin", 4, 4, 24'h00FFFF);
    check_pixel("after reset no lives", 28, 4, 24'h000000);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
